// File: rtl/sram_seq_pkg.sv
// Shared types and constants for the SRAM bus sequencer: FSM state encoding,
// requester identifiers and the bus data width.
package sram_seq_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_LATCH    = 3'd2,
    ST_RD_OE    = 3'd3,
    ST_RD_DONE  = 3'd4,
    ST_WR_SETUP = 3'd5,
    ST_WR_PULSE = 3'd6,
    ST_WR_DONE  = 3'd7
  } seq_state_t;

  typedef enum logic {
    REQ_CPU  = 1'b0,
    REQ_HOST = 1'b1
  } req_id_t;

  // True on the last cycle of a strobe phase that lasts 1+wait_cycles cycles
  function automatic logic dwell_done(input logic [3:0] cnt, input logic [3:0] wait_cycles);
    return (cnt == wait_cycles);
  endfunction

endpackage

// File: rtl/sram_bus_sequencer_if.sv
// Requester handshakes plus the external IO bus / SRAM strobe signals of the
// sequencer; slave is the sequencer side, master the requesters/board side.
interface sram_bus_sequencer_if;
  import sram_seq_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              host_req;
  logic              host_we;
  logic [DATA_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;

  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic              mem_latch_clk;
  logic              mem_oe_n;
  logic              mem_we_n;
  logic              out_latch_clk;
  logic              busy;
  logic              grant_host;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  host_req, host_we, host_addr, host_wdata,
    input  bus_in,
    output cpu_ack, cpu_rdata, host_ack, host_rdata,
    output bus_out, bus_oe, mem_latch_clk, mem_oe_n, mem_we_n,
    output out_latch_clk, busy, grant_host
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output host_req, host_we, host_addr, host_wdata,
    output bus_in,
    input  cpu_ack, cpu_rdata, host_ack, host_rdata,
    input  bus_out, bus_oe, mem_latch_clk, mem_oe_n, mem_we_n,
    input  out_latch_clk, busy, grant_host
  );

endinterface

// File: rtl/sram_seq_arbiter.sv
// Two-way grant logic for the sequencer. With SRAM_SEQ_RR_EN defined a tie goes
// to the requester not granted last; otherwise the host always wins a tie.
module sram_seq_arbiter
  import sram_seq_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    i_sample,
  input  logic    i_cpu_req,
  input  logic    i_host_req,
  output logic    o_grant_valid,
  output req_id_t o_grant_id
);

  assign o_grant_valid = i_cpu_req | i_host_req;

`ifdef SRAM_SEQ_RR_EN
  req_id_t r_last;

  // Winner selection: a lone request always wins, a tie goes against r_last
  always_comb begin
    o_grant_id = REQ_CPU;
    if (i_cpu_req && i_host_req) begin
      o_grant_id = (r_last == REQ_HOST) ? REQ_CPU : REQ_HOST;
    end else if (i_host_req) begin
      o_grant_id = REQ_HOST;
    end else begin
      o_grant_id = REQ_CPU;
    end
  end

  // Pointer reset to CPU so the host wins the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= REQ_CPU;
    end else if (i_sample && o_grant_valid) begin
      r_last <= o_grant_id;
    end else begin
      r_last <= r_last;
    end
  end
`else
  logic w_unused;

  assign o_grant_id = i_host_req ? REQ_HOST : REQ_CPU;
  assign w_unused   = ^{clk, reset, i_sample};
`endif

endmodule

// File: rtl/sram_bus_sequencer.sv
// Serialises CPU/host byte transactions onto the address-latch + SRAM IO bus.
// Optional round-robin arbitration is enabled by defining SRAM_SEQ_RR_EN.
module sram_bus_sequencer
  import sram_seq_pkg::*;
#(
  parameter int unsigned       WAIT_CYCLES = 0,
  parameter logic [DATA_W-1:0] IO_ADDR     = 8'hFF
) (
  input  logic                clk,
  input  logic                reset,
  sram_bus_sequencer_if.slave bus
);

  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  seq_state_t        r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic              r_we, w_we_nxt;
  logic [DATA_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  req_id_t           r_owner, w_owner_nxt;
  logic [DATA_W-1:0] r_bus_out, w_bus_out_nxt;
  logic              r_bus_oe, w_bus_oe_nxt;
  logic              r_latch, w_latch_nxt;
  logic              r_oe_n, w_oe_n_nxt;
  logic              r_we_n, w_we_n_nxt;
  logic              r_olc, w_olc_nxt;
  logic              r_cpu_ack, w_cpu_ack_nxt;
  logic              r_host_ack, w_host_ack_nxt;
  logic [DATA_W-1:0] r_cpu_rdata, w_cpu_rdata_nxt;
  logic [DATA_W-1:0] r_host_rdata, w_host_rdata_nxt;
  logic              r_busy;

  logic              w_grant_valid;
  req_id_t           w_grant_id;

  sram_seq_arbiter u_arbiter (
    .clk           (clk),
    .reset         (reset),
    .i_sample      (r_state == ST_IDLE),
    .i_cpu_req     (bus.cpu_req),
    .i_host_req    (bus.host_req),
    .o_grant_valid (w_grant_valid),
    .o_grant_id    (w_grant_id)
  );

  // Next-state and next-output logic; every output is registered below
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_we_nxt         = r_we;
    w_addr_nxt       = r_addr;
    w_wdata_nxt      = r_wdata;
    w_owner_nxt      = r_owner;
    w_bus_out_nxt    = r_bus_out;
    w_bus_oe_nxt     = r_bus_oe;
    w_latch_nxt      = r_latch;
    w_oe_n_nxt       = r_oe_n;
    w_we_n_nxt       = r_we_n;
    w_olc_nxt        = r_olc;
    w_cpu_ack_nxt    = r_cpu_ack;
    w_host_ack_nxt   = r_host_ack;
    w_cpu_rdata_nxt  = r_cpu_rdata;
    w_host_rdata_nxt = r_host_rdata;

    case (r_state)
      ST_IDLE: begin
        if (w_grant_valid) begin
          w_owner_nxt   = w_grant_id;
          w_we_nxt      = (w_grant_id == REQ_HOST) ? bus.host_we    : bus.cpu_we;
          w_addr_nxt    = (w_grant_id == REQ_HOST) ? bus.host_addr  : bus.cpu_addr;
          w_wdata_nxt   = (w_grant_id == REQ_HOST) ? bus.host_wdata : bus.cpu_wdata;
          w_bus_out_nxt = (w_grant_id == REQ_HOST) ? bus.host_addr  : bus.cpu_addr;
          w_bus_oe_nxt  = 1'b1;
          w_latch_nxt   = 1'b0;
          w_state_nxt   = ST_ADDR;
        end else begin
          w_state_nxt   = ST_IDLE;
        end
      end
      ST_ADDR: begin
        w_latch_nxt = 1'b1;
        w_state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        w_cnt_nxt = 4'd0;
        if (r_we) begin
          w_bus_out_nxt = r_wdata;
          w_state_nxt   = ST_WR_SETUP;
        end else begin
          w_bus_oe_nxt  = 1'b0;
          w_oe_n_nxt    = 1'b0;
          w_state_nxt   = ST_RD_OE;
        end
      end
      ST_RD_OE: begin
        if (dwell_done(r_cnt, LP_WAIT)) begin
          w_oe_n_nxt = 1'b1;
          if (r_owner == REQ_HOST) begin
            w_host_rdata_nxt = bus.bus_in;
            w_host_ack_nxt   = 1'b1;
          end else begin
            w_cpu_rdata_nxt  = bus.bus_in;
            w_cpu_ack_nxt    = 1'b1;
          end
          w_state_nxt = ST_RD_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      ST_WR_SETUP: begin
        // Writes to the IO address strobe the output latch, never the SRAM
        if (r_addr == IO_ADDR) begin
          w_olc_nxt  = 1'b1;
        end else begin
          w_we_n_nxt = 1'b0;
        end
        w_cnt_nxt   = 4'd0;
        w_state_nxt = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        if (dwell_done(r_cnt, LP_WAIT)) begin
          w_olc_nxt  = 1'b0;
          w_we_n_nxt = 1'b1;
          if (r_owner == REQ_HOST) begin
            w_host_ack_nxt = 1'b1;
          end else begin
            w_cpu_ack_nxt  = 1'b1;
          end
          w_state_nxt = ST_WR_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      ST_RD_DONE, ST_WR_DONE: begin
        w_cpu_ack_nxt  = 1'b0;
        w_host_ack_nxt = 1'b0;
        w_bus_oe_nxt   = 1'b0;
        w_state_nxt    = ST_IDLE;
      end
      default: begin
        w_cpu_ack_nxt  = 1'b0;
        w_host_ack_nxt = 1'b0;
        w_bus_oe_nxt   = 1'b0;
        w_oe_n_nxt     = 1'b1;
        w_we_n_nxt     = 1'b1;
        w_olc_nxt      = 1'b0;
        w_state_nxt    = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 4'd0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_owner      <= REQ_CPU;
      r_bus_out    <= '0;
      r_bus_oe     <= 1'b0;
      r_latch      <= 1'b0;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_olc        <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_host_ack   <= 1'b0;
      r_cpu_rdata  <= '0;
      r_host_rdata <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_we         <= w_we_nxt;
      r_addr       <= w_addr_nxt;
      r_wdata      <= w_wdata_nxt;
      r_owner      <= w_owner_nxt;
      r_bus_out    <= w_bus_out_nxt;
      r_bus_oe     <= w_bus_oe_nxt;
      r_latch      <= w_latch_nxt;
      r_oe_n       <= w_oe_n_nxt;
      r_we_n       <= w_we_n_nxt;
      r_olc        <= w_olc_nxt;
      r_cpu_ack    <= w_cpu_ack_nxt;
      r_host_ack   <= w_host_ack_nxt;
      r_cpu_rdata  <= w_cpu_rdata_nxt;
      r_host_rdata <= w_host_rdata_nxt;
      r_busy       <= (w_state_nxt != ST_IDLE);
    end
  end

  assign bus.cpu_ack       = r_cpu_ack;
  assign bus.cpu_rdata     = r_cpu_rdata;
  assign bus.host_ack      = r_host_ack;
  assign bus.host_rdata    = r_host_rdata;
  assign bus.bus_out       = r_bus_out;
  assign bus.bus_oe        = r_bus_oe;
  assign bus.mem_latch_clk = r_latch;
  assign bus.mem_oe_n      = r_oe_n;
  assign bus.mem_we_n      = r_we_n;
  assign bus.out_latch_clk = r_olc;
  assign bus.busy          = r_busy;
  assign bus.grant_host    = (r_owner == REQ_HOST);

endmodule

// File: tb/tb_sram_bus_sequencer.sv
// Directed self-checking bench for sram_bus_sequencer with a behavioural
// address latch, SRAM and output latch on the IO bus.
module tb_sram_bus_sequencer;

  localparam int W = 2;

  logic clk = 1'b0;
  logic reset;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   fail_cnt  = 0;
  int   viol      = 0;

  logic [7:0] mem [256];
  logic [7:0] lat_addr    = 8'h00;
  logic [7:0] out_latch_q = 8'h00;
  logic       prev_latch  = 1'b0;

  sram_bus_sequencer_if bus_if ();

  sram_bus_sequencer #(
    .WAIT_CYCLES (W),
    .IO_ADDR     (8'hFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  assign bus_if.bus_in = bus_if.mem_oe_n ? 8'hEE : mem[lat_addr];

  always @(posedge bus_if.mem_latch_clk) lat_addr <= bus_if.bus_out;

  always @(posedge bus_if.mem_we_n) begin
    if (!reset) mem[lat_addr] <= bus_if.bus_out;
  end

  always @(posedge bus_if.out_latch_clk) out_latch_q <= bus_if.bus_out;

  always @(negedge clk) begin
    if (!reset && !bus_if.mem_oe_n && (!bus_if.mem_we_n || bus_if.mem_latch_clk != prev_latch))
      viol <= viol + 1;
    prev_latch <= bus_if.mem_latch_clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    int   seen;
    int   cyc;
    logic exp_host;

    reset = 1'b1;
    bus_if.cpu_req = 1'b0;  bus_if.cpu_we = 1'b0;  bus_if.cpu_addr = 8'h00;  bus_if.cpu_wdata = 8'h00;
    bus_if.host_req = 1'b0; bus_if.host_we = 1'b0; bus_if.host_addr = 8'h00; bus_if.host_wdata = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    #1;
    mem[8'h12] <= 8'h5A;
    mem[8'hFF] <= 8'h77;
    mem[8'h34] <= 8'hA6;

    // Reset state
    repeat (3) tick();
    chk("rst_busy",     32'(bus_if.busy), 32'd0);
    chk("rst_bus_oe",   32'(bus_if.bus_oe), 32'd0);
    chk("rst_oe_n",     32'(bus_if.mem_oe_n), 32'd1);
    chk("rst_we_n",     32'(bus_if.mem_we_n), 32'd1);
    chk("rst_latch",    32'(bus_if.mem_latch_clk), 32'd0);
    chk("rst_bus_out",  32'(bus_if.bus_out), 32'd0);
    chk("rst_grant",    32'(bus_if.grant_host), 32'd0);
    reset = 1'b0;
    tick();

    // CPU read 0x12
    bus_if.cpu_we = 1'b0; bus_if.cpu_addr = 8'h12; bus_if.cpu_req = 1'b1;
    tick();
    chk("rd_e0_bus_out", 32'(bus_if.bus_out), 32'h12);
    chk("rd_e0_bus_oe",  32'(bus_if.bus_oe), 32'd1);
    chk("rd_e0_latch",   32'(bus_if.mem_latch_clk), 32'd0);
    chk("rd_e0_busy",    32'(bus_if.busy), 32'd1);
    chk("rd_e0_grant",   32'(bus_if.grant_host), 32'd0);
    bus_if.cpu_addr = 8'h99;
    tick();
    chk("rd_e1_latch",   32'(bus_if.mem_latch_clk), 32'd1);
    chk("rd_e1_oe_n",    32'(bus_if.mem_oe_n), 32'd1);
    tick();
    chk("rd_e2_oe_n",    32'(bus_if.mem_oe_n), 32'd0);
    chk("rd_e2_bus_oe",  32'(bus_if.bus_oe), 32'd0);
    for (int i = 0; i < W; i++) begin
      tick();
      chk("rd_dwell_oe_n", 32'(bus_if.mem_oe_n), 32'd0);
      chk("rd_dwell_ack",  32'(bus_if.cpu_ack), 32'd0);
    end
    tick();
    chk("rd_ack",        32'(bus_if.cpu_ack), 32'd1);
    chk("rd_rdata",      32'(bus_if.cpu_rdata), 32'h5A);
    chk("rd_oe_release", 32'(bus_if.mem_oe_n), 32'd1);
    bus_if.cpu_req = 1'b0;
    tick();
    chk("rd_done_ack",   32'(bus_if.cpu_ack), 32'd0);
    chk("rd_done_busy",  32'(bus_if.busy), 32'd0);
    chk("rd_rdata_hold", 32'(bus_if.cpu_rdata), 32'h5A);

    // Host write 0x40 <= 0xC3
    bus_if.host_we = 1'b1; bus_if.host_addr = 8'h40; bus_if.host_wdata = 8'hC3; bus_if.host_req = 1'b1;
    tick();
    chk("wr_e0_grant",   32'(bus_if.grant_host), 32'd1);
    chk("wr_e0_bus_out", 32'(bus_if.bus_out), 32'h40);
    bus_if.host_wdata = 8'h00;
    tick();
    tick();
    chk("wr_e2_data",    32'(bus_if.bus_out), 32'hC3);
    chk("wr_e2_bus_oe",  32'(bus_if.bus_oe), 32'd1);
    chk("wr_e2_we_n",    32'(bus_if.mem_we_n), 32'd1);
    cyc = 0;
    for (int i = 0; i < W + 1; i++) begin
      tick();
      if (bus_if.mem_we_n == 1'b0) cyc++;
      chk("wr_pulse_data", 32'(bus_if.bus_out), 32'hC3);
    end
    chk("wr_we_low_cycles", 32'(cyc), 32'(W + 1));
    tick();
    chk("wr_we_release", 32'(bus_if.mem_we_n), 32'd1);
    chk("wr_ack",        32'(bus_if.host_ack), 32'd1);
    chk("wr_done_data",  32'(bus_if.bus_out), 32'hC3);
    bus_if.host_req = 1'b0;
    tick();
    chk("wr_done_ack",   32'(bus_if.host_ack), 32'd0);
    chk("wr_mem_40",     32'(mem[8'h40]), 32'hC3);

    // CPU write to the IO address
    bus_if.cpu_we = 1'b1; bus_if.cpu_addr = 8'hFF; bus_if.cpu_wdata = 8'h81; bus_if.cpu_req = 1'b1;
    repeat (4) tick();
    chk("io_olc_high",   32'(bus_if.out_latch_clk), 32'd1);
    chk("io_we_n",       32'(bus_if.mem_we_n), 32'd1);
    chk("io_bus_out",    32'(bus_if.bus_out), 32'h81);
    repeat (W + 1) tick();
    chk("io_olc_low",    32'(bus_if.out_latch_clk), 32'd0);
    chk("io_ack",        32'(bus_if.cpu_ack), 32'd1);
    bus_if.cpu_req = 1'b0;
    tick();
    chk("io_out_latch",  32'(out_latch_q), 32'h81);
    chk("io_mem_ff",     32'(mem[8'hFF]), 32'h77);

    // Both requesting continuously
    bus_if.cpu_we = 1'b0;  bus_if.cpu_addr = 8'h12;
    bus_if.host_we = 1'b0; bus_if.host_addr = 8'h40;
    bus_if.cpu_req = 1'b1; bus_if.host_req = 1'b1;
    for (int t = 0; t < 4; t++) begin
      seen = 0;
      for (int k = 0; k < 20 && seen == 0; k++) begin
        tick();
        if (bus_if.cpu_ack || bus_if.host_ack) seen = 1;
      end
      chk("arb_ack_seen", 32'(seen), 32'd1);
`ifdef SRAM_SEQ_RR_EN
      exp_host = (t % 2 == 0);
`else
      exp_host = 1'b1;
`endif
      chk("arb_host_ack",   32'(bus_if.host_ack), 32'(exp_host));
      chk("arb_grant_host", 32'(bus_if.grant_host), 32'(exp_host));
      if (exp_host) chk("arb_host_rdata", 32'(bus_if.host_rdata), 32'hC3);
      else          chk("arb_cpu_rdata",  32'(bus_if.cpu_rdata), 32'h5A);
    end
    bus_if.cpu_req = 1'b0; bus_if.host_req = 1'b0;
    for (int k = 0; k < 20 && bus_if.busy; k++) tick();
    chk("arb_idle", 32'(bus_if.busy), 32'd0);

    // Reset during RD_OE
    bus_if.cpu_we = 1'b0; bus_if.cpu_addr = 8'h12; bus_if.cpu_req = 1'b1;
    repeat (4) tick();
    chk("mid_oe_active", 32'(bus_if.mem_oe_n), 32'd0);
    reset = 1'b1; bus_if.cpu_req = 1'b0;
    tick();
    chk("mid_rst_bus_oe",  32'(bus_if.bus_oe), 32'd0);
    chk("mid_rst_oe_n",    32'(bus_if.mem_oe_n), 32'd1);
    chk("mid_rst_we_n",    32'(bus_if.mem_we_n), 32'd1);
    chk("mid_rst_latch",   32'(bus_if.mem_latch_clk), 32'd0);
    chk("mid_rst_olc",     32'(bus_if.out_latch_clk), 32'd0);
    chk("mid_rst_bus_out", 32'(bus_if.bus_out), 32'd0);
    chk("mid_rst_cpu_ack", 32'(bus_if.cpu_ack), 32'd0);
    chk("mid_rst_rdata",   32'(bus_if.cpu_rdata), 32'd0);
    chk("mid_rst_hrdata",  32'(bus_if.host_rdata), 32'd0);
    chk("mid_rst_busy",    32'(bus_if.busy), 32'd0);
    chk("mid_rst_grant",   32'(bus_if.grant_host), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_no_ack", 32'(bus_if.cpu_ack), 32'd0);
    bus_if.cpu_addr = 8'h34; bus_if.cpu_req = 1'b1;
    seen = 0; cyc = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      tick();
      cyc++;
      if (bus_if.cpu_ack) seen = 1;
    end
    chk("post_rst_ack_seen",  32'(seen), 32'd1);
    chk("post_rst_latency",   32'(cyc), 32'(4 + W));
    chk("post_rst_rdata",     32'(bus_if.cpu_rdata), 32'hA6);
    bus_if.cpu_req = 1'b0;
    repeat (2) tick();
    chk("oe_we_latch_overlap", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
